// File: rtl/shreg_pkg.sv
// Shared types for the shreg_burst shift register: fill modes, burst FSM states
// and shift-direction encodings.
package shreg_pkg;

    typedef enum logic [1:0] {
        SHREG_SERIAL = 2'b00,
        SHREG_ZERO   = 2'b01,
        SHREG_ROTATE = 2'b10,
        SHREG_ARITH  = 2'b11
    } shreg_mode_e;

    typedef enum logic {
        SHREG_IDLE = 1'b0,
        SHREG_RUN  = 1'b1
    } shreg_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shreg_burst_if.sv
// Command/status bundle between a controller (master) and shreg_burst (slave).
// parity_out exists only when SHREG_BURST_PARITY_EN is defined.
interface shreg_burst_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load;
    logic [WIDTH-1:0] parallel_in;
    logic             shift;
    logic             dir;
    logic [1:0]       mode;
    logic             serial_in;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] data_out;
    logic             serial_out;
    logic             busy;
    logic             done;
`ifdef SHREG_BURST_PARITY_EN
    logic             parity_out;

    modport master (
        output load, parallel_in, shift, dir, mode, serial_in, burst_start, burst_len,
        input  data_out, serial_out, busy, done, parity_out
    );

    modport slave (
        input  load, parallel_in, shift, dir, mode, serial_in, burst_start, burst_len,
        output data_out, serial_out, busy, done, parity_out
    );
`else
    modport master (
        output load, parallel_in, shift, dir, mode, serial_in, burst_start, burst_len,
        input  data_out, serial_out, busy, done
    );

    modport slave (
        input  load, parallel_in, shift, dir, mode, serial_in, burst_start, burst_len,
        output data_out, serial_out, busy, done
    );
`endif
endinterface

// File: rtl/shreg_shift_unit.sv
// Combinational single-step shift: computes the register value after one shift
// with the given fill mode and direction.
module shreg_shift_unit
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  shreg_mode_e      mode,
    input  logic             dir,
    input  logic             serial_in,
    output logic [WIDTH-1:0] value_next
);

    logic fill_s;

    // Bit entering the vacated position, then the shift itself.
    always_comb begin
        fill_s     = 1'b0;
        value_next = value;
        case (mode)
            SHREG_SERIAL: fill_s = serial_in;
            SHREG_ZERO:   fill_s = 1'b0;
            SHREG_ROTATE: fill_s = (dir == DIR_RIGHT) ? value[0] : value[WIDTH-1];
            SHREG_ARITH:  fill_s = (dir == DIR_RIGHT) ? value[WIDTH-1] : 1'b0;
            default:      fill_s = 1'b0;
        endcase
        if (dir == DIR_RIGHT) begin
            value_next = {fill_s, value[WIDTH-1:1]};
        end else begin
            value_next = {value[WIDTH-2:0], fill_s};
        end
    end

endmodule

// File: rtl/shreg_burst.sv
// Parametrised load/shift register with a counted burst-shift engine.
// Optional registered parity output enabled by defining SHREG_BURST_PARITY_EN.
module shreg_burst
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    shreg_burst_if.slave    bus
);

    shreg_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    shreg_mode_e      mode_lat_q, mode_lat_d;
    logic             dir_lat_q, dir_lat_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    shreg_mode_e      step_mode_s;
    logic             step_dir_s;
    logic [WIDTH-1:0] step_value_s;

    // A running burst uses the mode/dir captured at its start; otherwise live inputs.
    always_comb begin
        if (state_q == SHREG_RUN) begin
            step_mode_s = mode_lat_q;
            step_dir_s  = dir_lat_q;
        end else begin
            step_mode_s = shreg_mode_e'(bus.mode);
            step_dir_s  = bus.dir;
        end
    end

    shreg_shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift (
        .value      (data_q),
        .mode       (step_mode_s),
        .dir        (step_dir_s),
        .serial_in  (bus.serial_in),
        .value_next (step_value_s)
    );

    // Next-state logic: load > burst continuation > burst start > single shift > hold.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_lat_d = mode_lat_q;
        dir_lat_d  = dir_lat_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (bus.load) begin
            data_d  = bus.parallel_in;
            state_d = SHREG_IDLE;
            busy_d  = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                SHREG_RUN: begin
                    data_d = step_value_s;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = SHREG_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
                SHREG_IDLE: begin
                    if (bus.burst_start) begin
                        if (bus.burst_len == {CNT_W{1'b0}}) begin
                            done_d = 1'b1;
                        end else begin
                            data_d     = step_value_s;
                            mode_lat_d = shreg_mode_e'(bus.mode);
                            dir_lat_d  = bus.dir;
                            cnt_d      = bus.burst_len - CNT_W'(1);
                            if (bus.burst_len == CNT_W'(1)) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = SHREG_RUN;
                                busy_d  = 1'b1;
                            end
                        end
                    end else if (bus.shift) begin
                        data_d = step_value_s;
                    end else begin
                        data_d = data_q;
                    end
                end
                default: begin
                    state_d = SHREG_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SHREG_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            mode_lat_q <= SHREG_SERIAL;
            dir_lat_q  <= 1'b0;
            data_q     <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_lat_q <= mode_lat_d;
            dir_lat_q  <= dir_lat_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    // Bit the next shift would eject, following the direction that shift would use.
    assign bus.serial_out = (step_dir_s == DIR_RIGHT) ? data_q[0] : data_q[WIDTH-1];

`ifdef SHREG_BURST_PARITY_EN
    logic parity_q, parity_d;

    function automatic logic calc_parity(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    // Parity tracks the next data value so it lines up with data_out.
    always_comb begin
        parity_d = calc_parity(data_d);
    end

    // Parity register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign bus.parity_out = parity_q;
`endif

endmodule

// File: tb/tb_shreg_burst.sv
// Self-checking bench for shreg_burst (WIDTH=8, CNT_W=4): directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_shreg_burst;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    shreg_burst_if #(.WIDTH(8), .CNT_W(4)) bus_if ();

    shreg_burst #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] m_data;
    int         m_rem;
    int         m_mode;
    bit         m_dir;
    bit         m_done;

    function automatic logic [7:0] ref_shift(input logic [7:0] v, input int md, input bit dr, input bit sin);
        int x;
        int fill;
        x = int'(v);
        case (md)
            0: fill = int'(sin);
            1: fill = 0;
            2: fill = dr ? (x % 2) : (x / 128);
            3: fill = dr ? (x / 128) : 0;
            default: fill = 0;
        endcase
        if (dr) return 8'(x / 2 + fill * 128);
        else    return 8'((x * 2) % 256 + fill);
    endfunction

    task automatic idle_inputs();
        bus_if.load        = 1'b0;
        bus_if.parallel_in = 8'h00;
        bus_if.shift       = 1'b0;
        bus_if.dir         = 1'b0;
        bus_if.mode        = 2'b00;
        bus_if.serial_in   = 1'b0;
        bus_if.burst_start = 1'b0;
        bus_if.burst_len   = 4'd0;
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        idle_inputs();
        bus_if.load        = 1'b1;
        bus_if.parallel_in = v;
        cycle();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (bus_if.data_out !== 8'h00 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: data=%h busy=%b done=%b, required 00/0/0", bus_if.data_out, bus_if.busy, bus_if.done);
        end
        cycle();
        reset = 1'b0;
        do_load(8'hFF);
        bus_if.burst_start = 1'b1;
        bus_if.burst_len   = 4'd5;
        bus_if.mode        = 2'b01;
        bus_if.dir         = 1'b1;
        cycle();
        bus_if.burst_start = 1'b0;
        cycle();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus_if.data_out !== 8'h00 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midburst: data=%h busy=%b done=%b, required 00/0/0", bus_if.data_out, bus_if.busy, bus_if.done);
        end
        #1 reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (bus_if.data_out !== 8'h00 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_after[%0d]: data=%h busy=%b done=%b, required 00/0/0", i, bus_if.data_out, bus_if.busy, bus_if.done);
            end
        end
    endtask

    task automatic test_load_priority();
        idle_inputs();
        bus_if.load        = 1'b1;
        bus_if.parallel_in = 8'hA5;
        bus_if.shift       = 1'b1;
        bus_if.mode        = 2'b01;
        cycle();
        idle_inputs();
        n_checks++;
        if (bus_if.data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL load_priority: data=%h, required a5", bus_if.data_out);
        end
    endtask

    task automatic test_single_shift();
        logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic       dirs  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp   [4] = '{8'h02, 8'h03, 8'hC0, 8'hC0};
        for (int i = 0; i < 4; i++) begin
            do_load(8'h81);
            bus_if.shift     = 1'b1;
            bus_if.mode      = modes[i];
            bus_if.dir       = dirs[i];
            bus_if.serial_in = 1'b1;
            cycle();
            idle_inputs();
            n_checks++;
            if (bus_if.data_out !== exp[i] || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_shift[%0d]: data=%h busy=%b done=%b, required %h/0/0", i, bus_if.data_out, bus_if.busy, bus_if.done, exp[i]);
            end
        end
    endtask

    task automatic test_burst3();
        logic [7:0] exp_d [4] = '{8'h02, 8'h04, 8'h08, 8'h08};
        logic       exp_b [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_n [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_load(8'h01);
        bus_if.burst_start = 1'b1;
        bus_if.burst_len   = 4'd3;
        bus_if.mode        = 2'b01;
        bus_if.dir         = 1'b0;
        bus_if.shift       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (i < 2) begin
                bus_if.burst_start = 1'b0;
                bus_if.dir         = 1'b1;
                bus_if.mode        = 2'b10;
            end else begin
                idle_inputs();
            end
            n_checks++;
            if (bus_if.data_out !== exp_d[i] || bus_if.busy !== exp_b[i] || bus_if.done !== exp_n[i]) begin
                n_fail++;
                $display("FAIL burst3[%0d]: data=%h busy=%b done=%b, required %h/%b/%b", i, bus_if.data_out, bus_if.busy, bus_if.done, exp_d[i], exp_b[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_abort();
        do_load(8'hFF);
        bus_if.burst_start = 1'b1;
        bus_if.burst_len   = 4'd5;
        bus_if.mode        = 2'b01;
        bus_if.dir         = 1'b1;
        cycle();
        bus_if.burst_start = 1'b0;
        cycle();
        n_checks++;
        if (bus_if.data_out !== 8'h3F || bus_if.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: data=%h busy=%b, required 3f/1", bus_if.data_out, bus_if.busy);
        end
        bus_if.load        = 1'b1;
        bus_if.parallel_in = 8'h3C;
        cycle();
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus_if.data_out !== 8'h3C || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort[%0d]: data=%h busy=%b done=%b, required 3c/0/0", i, bus_if.data_out, bus_if.busy, bus_if.done);
            end
            cycle();
        end
    endtask

    task automatic test_len0_len1();
        do_load(8'h5A);
        bus_if.burst_start = 1'b1;
        bus_if.burst_len   = 4'd0;
        cycle();
        idle_inputs();
        n_checks++;
        if (bus_if.data_out !== 8'h5A || bus_if.busy !== 1'b0 || bus_if.done !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_pulse: data=%h busy=%b done=%b, required 5a/0/1", bus_if.data_out, bus_if.busy, bus_if.done);
        end
        cycle();
        n_checks++;
        if (bus_if.data_out !== 8'h5A || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_after: data=%h busy=%b done=%b, required 5a/0/0", bus_if.data_out, bus_if.busy, bus_if.done);
        end
        bus_if.burst_start = 1'b1;
        bus_if.burst_len   = 4'd1;
        bus_if.mode        = 2'b01;
        bus_if.dir         = 1'b0;
        cycle();
        idle_inputs();
        n_checks++;
        if (bus_if.data_out !== 8'hB4 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b1) begin
            n_fail++;
            $display("FAIL len1_pulse: data=%h busy=%b done=%b, required b4/0/1", bus_if.data_out, bus_if.busy, bus_if.done);
        end
        cycle();
        n_checks++;
        if (bus_if.data_out !== 8'hB4 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_after: data=%h busy=%b done=%b, required b4/0/0", bus_if.data_out, bus_if.busy, bus_if.done);
        end
    endtask

    task automatic test_random();
        bit         ld, bs, sh, dr, sin, e_so, dsel;
        int         md, len;
        logic [7:0] pin;
        m_rem  = 0;
        m_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            ld  = (i == 0) || ($urandom_range(0, 15) == 0);
            bs  = ($urandom_range(0, 5) == 0);
            sh  = $urandom_range(0, 1) == 1;
            dr  = $urandom_range(0, 1) == 1;
            sin = $urandom_range(0, 1) == 1;
            md  = int'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
            pin = 8'($urandom_range(0, 255));
            bus_if.load        = ld;
            bus_if.parallel_in = pin;
            bus_if.burst_start = bs;
            bus_if.burst_len   = 4'(len);
            bus_if.shift       = sh;
            bus_if.dir         = dr;
            bus_if.serial_in   = sin;
            bus_if.mode        = 2'(md);

            if (ld) begin
                m_data = pin;
                m_rem  = 0;
                m_done = 1'b0;
            end else if (m_rem > 0) begin
                m_data = ref_shift(m_data, m_mode, m_dir, sin);
                m_rem  = m_rem - 1;
                m_done = (m_rem == 0);
            end else if (bs) begin
                if (len == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_mode = md;
                    m_dir  = dr;
                    m_data = ref_shift(m_data, md, dr, sin);
                    m_rem  = len - 1;
                    m_done = (m_rem == 0);
                end
            end else begin
                if (sh) m_data = ref_shift(m_data, md, dr, sin);
                m_done = 1'b0;
            end

            cycle();
            dsel = (m_rem > 0) ? m_dir : dr;
            e_so = dsel ? m_data[0] : m_data[7];
            n_checks++;
            if (bus_if.data_out !== m_data || bus_if.busy !== (m_rem > 0) ||
                bus_if.done !== m_done || bus_if.serial_out !== e_so) begin
                n_fail++;
                $display("FAIL random[%0d]: data=%h busy=%b done=%b so=%b, required %h/%b/%b/%b",
                         i, bus_if.data_out, bus_if.busy, bus_if.done, bus_if.serial_out,
                         m_data, (m_rem > 0), m_done, e_so);
            end
`ifdef SHREG_BURST_PARITY_EN
            n_checks++;
            if (bus_if.parity_out !== ^m_data) begin
                n_fail++;
                $display("FAIL parity[%0d]: parity=%b, required %b", i, bus_if.parity_out, ^m_data);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_priority();
        test_single_shift();
        test_burst3();
        test_abort();
        test_len0_len1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shreg_burst.md
Name: shreg_burst

Overview:
- Parametrised successor to the team's 8-bit load/shift register.
- Adds generic width, four fill modes (serial, zero, rotate, arithmetic) in both directions, and a serial output.
- Adds a counted multi-cycle burst-shift engine with busy/done handshake.
- Sits in datapath serialisers/deserialisers; the controller issues load, single-step or burst shift commands.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of burst_len; max burst = 2**CNT_W-1 shifts.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  parallel load of parallel_in
- parallel_in  in  WIDTH  parallel load value
- shift  in  1  single-step shift request
- dir  in  1  0 = shift left (toward MSB), 1 = shift right
- mode  in  2  00 SERIAL fill, 01 ZERO fill, 10 ROTATE, 11 ARITH
- serial_in  in  1  fill bit for SERIAL mode
- burst_start  in  1  start a counted burst
- burst_len  in  CNT_W  number of shifts in the burst
- data_out  out  WIDTH  register contents
- serial_out  out  1  bit that the next shift will eject: data_out[WIDTH-1] if dir=0, data_out[0] if dir=1 (uses live dir in IDLE, latched dir in RUN)
- busy  out  1  burst in progress, further shifts pending
- done  out  1  one-cycle pulse after the final burst shift

Behaviour:
- Reset (async, active-high): data_out=0, busy=0, done=0, state=IDLE, counter=0, latched mode/dir=0.
- Fill rules per shift (one bit per edge):
  - SERIAL: vacated bit = serial_in.
  - ZERO: vacated bit = 0.
  - ROTATE: ejected bit re-enters the vacated position.
  - ARITH: right shift replicates MSB; left shift zero-fills.
- Priority per edge: reset > load > RUN continuation > burst_start > shift > hold.
  - Idle register holds its value. It does not reload as the previous generation did.
- load:
  - data_out <= parallel_in next cycle, in any state.
  - In RUN, load aborts the burst: state->IDLE, busy=0, no done pulse.
- FSM states IDLE and RUN; counter of width CNT_W.
- IDLE, burst_start with burst_len=N>=1:
  - First shift on that edge, using live mode/dir.
  - mode/dir latched; counter <= N-1.
  - N=1: stay IDLE, done=1 next cycle.
  - N>1: ->RUN, busy=1.
- IDLE, burst_start with burst_len=0: data unchanged, no busy, done=1 next cycle.
- RUN:
  - Each edge performs one shift with the latched mode/dir and decrements the counter.
  - On the edge where counter goes 1->0: ->IDLE, busy<=0, done<=1 for exactly one cycle.
  - shift and burst_start are ignored in RUN; changes on the live mode/dir inputs have no effect.
- Total latency: N shifts occupy edges t..t+N-1. done is high in cycle t+N (after edge t+N-1). busy is high cycles t+1..t+N-1.
- Single shift in IDLE: one shift with live mode/dir, visible the next cycle; no busy, no done.
- Simultaneous burst_start+shift in IDLE: burst wins, and only one shift occurs on that edge.
- done is cleared on every edge where it is not being set.
- Reset mid-burst: immediate clear; no done pulse.

Optional Feature:
- Macro SHREG_BURST_PARITY_EN.
- When defined: extra output parity_out (1 bit), registered, equal to XOR of data_out. It updates in the same cycle as data_out (computed from next-state value) and is reset to 0.
- When undefined: port absent; no parity logic.

Decomposition:
- Package shreg_pkg:
  - shreg_mode_e enum (SHREG_SERIAL, SHREG_ZERO, SHREG_ROTATE, SHREG_ARITH)
  - shreg_state_e (SHREG_IDLE, SHREG_RUN)
  - DIR_LEFT/DIR_RIGHT constants
- Sub-module shreg_shift_unit: combinational single-step next-value function (WIDTH param; inputs value, mode, dir, serial_in). It is shared by the single-step and burst paths.

Test Plan:
- WIDTH=8: reset during activity -> data_out=0x00, busy=0, done=0 immediately (before next clk edge).
- load parallel_in=0xA5 together with shift=1 -> data_out=0xA5 next cycle (load wins).
- From 0x81, single shifts:
  - ZERO left -> 0x02.
  - ROTATE left -> 0x03.
  - ARITH right -> 0xC0.
  - SERIAL right with serial_in=1 -> 0xC0.
- From 0x01, burst_start, len=3, ZERO left:
  - data_out 0x02, 0x04, 0x08 on successive cycles.
  - busy high 2 cycles; done high one cycle, concurrent with 0x08.
  - Toggling live dir/mode during RUN has no effect.
- Burst len=5 from 0xFF, ZERO right; load 0x3C after 2 shifts -> data_out=0x3C, busy=0, no done pulse ever.
- burst_len=0 -> data unchanged, busy stays 0, done pulses once. burst_len=1 -> one shift, done next cycle, busy never high.
